pps_generator: RTL
==================

# pps_generator

Local 1PPS transmitter in the core clock domain. Keeps a sub-second tick counter and a 32-bit seconds counter, and drives a 1PPS output with a programmable phase offset and pulse width. The counters can free-run, or be aligned to a single-cycle reference pulse such as the disciplined 1PPS from the PPS receiver. Sits between timing recovery and board-level PPS/trigger outputs.

## Interface
- C_CLOCK_FREQUENCY, 125000000, clk ticks per second (F); sub-second counter runs 0..F-1
- C_MISS_LIMIT, 2, consecutive second boundaries without sync_in before lock is lost
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  output enable; gates pps_out only, counters always run
- cfg_phase  in  32  tick within the second at which pps_out rises; values >= F clamp to F-1
- cfg_pulse_width  in  32  high time in ticks; 0 is treated as 1; values >= F clamp to F-1
- cfg_sync_mode  in  2  0 = free-run, 1 = one-shot align, 2 = continuous align, 3 = same as 0
- sync_arm  in  1  single-cycle pulse; arms alignment (mode 1 or 2)
- sync_in  in  1  single-cycle reference pulse marking tick 0 of a second
- tod_load  in  1  single-cycle pulse; requests a seconds-counter load
- tod_value  in  32  seconds value for tod_load
- err_clear  in  1  clears stat_sync_err
- pps_out  out  1  1PPS output
- sub_sec  out  32  current tick counter, zero-extended
- seconds  out  32  seconds counter
- irq_second  out  1  single-cycle pulse on each seconds increment or load
- stat_locked  out  1  alignment FSM is in LOCKED
- stat_sync_err  out  1  sticky; set on any realignment with nonzero offset, or on loss of lock

## Operation
- **Boundary.** A boundary occurs on the natural wrap (sub_cnt == F-1 -> 0) or on an accepted realignment. The active phase and width are shadowed from the cfg inputs only at boundaries and on rst, so mid-second cfg changes never glitch the output.
- **Output.** pps_out is registered: pps_out <= enable && ((sub_cnt - phase_act) mod F) < width_act. A window that crosses F-1 wraps modulo F. Deasserting enable truncates a pulse in progress.
- **Alignment FSM**, states IDLE, ARMED, LOCKED:
  - IDLE -> ARMED on sync_arm when mode is 1 or 2.
  - ARMED: the first sync_in is accepted and the FSM moves to LOCKED.
  - LOCKED, mode 1: sync_in is ignored.
  - LOCKED, mode 2: every sync_in is accepted. Each boundary without a sync_in in the preceding second increments the miss counter; sync_in clears it. When the miss counter reaches C_MISS_LIMIT, set stat_sync_err and go to ARMED. The counters keep free-running (holdover).
  - Any state -> IDLE when mode is 0 or 3.
  - sync_arm in ARMED or LOCKED re-arms (-> ARMED).
- **Accepted sync_in when sub_cnt == k:**
  - k == 0: already aligned; no action.
  - k != 0: sub_cnt <= 1 on the next cycle, so the sync_in cycle is treated as tick 0. Set stat_sync_err. This is a boundary. The seconds counter increments only if k >= F/2 (integer division); otherwise the natural wrap has already counted this second.
- **Seconds and TOD.**
  - The seconds counter increments modulo 2^32 at each counted boundary.
  - tod_load captures tod_value into a pending register and sets a pending flag. At the first boundary strictly after the tod_load cycle, seconds <= pending value instead of incrementing, and irq_second pulses. A later tod_load before that boundary overwrites the pending value.
- **Errors.** err_clear has priority over a same-cycle set.

## Timing
- **Reset.** sub_cnt = 0, seconds = 0, pps_out = 0, irq_second = 0, stat_locked = 0, stat_sync_err = 0, FSM = IDLE, tod pending cleared, miss counter = 0. phase_act and width_act load the clamped cfg inputs.
- **First cycle after rst release.** sub_cnt = 0. With enable = 1 and phase 0, pps_out goes high on the following cycle.
- **Output latency.** pps_out lags sub_cnt by 1 cycle. irq_second and the seconds update are registered in the cycle where sub_cnt becomes 0 (or 1 after a realignment).
- **Simultaneous events.**
  - sync_in on the natural-wrap cycle (k = F-1): it is a realignment. Seconds increments once, not twice.
  - tod_load and a boundary in the same cycle: the load waits for the next boundary.
- **Mid-operation rst.** All state clears within one cycle; pps_out drops on the cycle after rst is sampled.
- **Arithmetic.** The tick counter width is $clog2(F). Modular subtraction is done in that width with a correction by +F when negative.

## Test plan
- **Free-run.** F = 100, phase 10, width 5, enable = 1: pps_out high at sub_sec 11..15 (ticks 10..14 +1 lag) each second; seconds increments every 100 cycles; irq_second 1-cycle pulses.
- **Wrap window.** F = 100, phase 98, width 4: pps_out covers ticks 98, 99, 0, 1; the cfg change to phase 50 mid-second takes effect only after the next boundary.
- **One-shot align.** Mode 1, sync_arm, then sync_in at sub_cnt 30: sub_sec = 1 next cycle, seconds unchanged, stat_sync_err = 1, stat_locked = 1. A later sync_in at 40 is ignored.
- **Continuous align.** Mode 2, sync_in at k = 70: seconds +1, irq_second pulses. Then stop sync_in: after 2 boundaries stat_locked = 0, stat_sync_err = 1, and the counters continue.
- **TOD.** tod_load with tod_value 0x1234 at sub_cnt 50: seconds = 0x1234 at the next wrap, irq_second pulses. A tod_load on the wrap cycle itself applies one second later.
- **Reset mid-pulse.** rst asserted while pps_out = 1: all outputs return to their reset values one cycle later; stat_sync_err clears; err_clear coincident with an error set leaves it 0.

Source files
------------

// File: rtl/pps_generator_if.sv
// Control, configuration and status bundle of the local 1PPS generator.
interface pps_generator_if;
  logic        enable;
  logic [31:0] cfg_phase;
  logic [31:0] cfg_pulse_width;
  logic [1:0]  cfg_sync_mode;
  logic        sync_arm;
  logic        sync_in;
  logic        tod_load;
  logic [31:0] tod_value;
  logic        err_clear;
  logic        pps_out;
  logic [31:0] sub_sec;
  logic [31:0] seconds;
  logic        irq_second;
  logic        stat_locked;
  logic        stat_sync_err;

  modport master (
    output enable, cfg_phase, cfg_pulse_width, cfg_sync_mode, sync_arm, sync_in,
           tod_load, tod_value, err_clear,
    input  pps_out, sub_sec, seconds, irq_second, stat_locked, stat_sync_err
  );

  modport slave (
    input  enable, cfg_phase, cfg_pulse_width, cfg_sync_mode, sync_arm, sync_in,
           tod_load, tod_value, err_clear,
    output pps_out, sub_sec, seconds, irq_second, stat_locked, stat_sync_err
  );
endinterface

// File: rtl/pps_generator.sv
// Local 1PPS transmitter: sub-second tick counter, seconds/TOD counter, phase/width
// programmable output and an IDLE/ARMED/LOCKED alignment FSM with holdover.
module pps_generator #(
  parameter int unsigned C_CLOCK_FREQUENCY = 125000000,
  parameter int unsigned C_MISS_LIMIT      = 2
) (
  input logic       clk,
  input logic       rst,
  pps_generator_if.slave bus
);
  localparam int unsigned F      = C_CLOCK_FREQUENCY;
  localparam int          W      = $clog2(F);
  localparam int          MW     = $clog2(C_MISS_LIMIT + 1);
  localparam int unsigned LAST_I = F - 1;
  localparam int unsigned HALF_I = F / 2;
  localparam logic [W-1:0]  LAST  = LAST_I[W-1:0];
  localparam logic [W-1:0]  HALF  = HALF_I[W-1:0];
  localparam logic [W-1:0]  F_W   = F[W-1:0];
  localparam logic [MW-1:0] LIMIT = C_MISS_LIMIT[MW-1:0];

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

  state_t         state;
  logic [W-1:0]   sub_cnt, phase_act, width_act, offset;
  logic [31:0]    sec_cnt, tod_val;
  logic [MW-1:0]  miss_cnt, miss_next;
  logic           tod_pend, seen_sync, locked, sync_err, pps, irq;
  logic           align_mode, accept, realign, wrap, boundary, count_inc, lock_lost;

  function automatic logic [W-1:0] clamp_phase(input logic [31:0] v);
    return (v >= F) ? LAST : v[W-1:0];
  endfunction

  function automatic logic [W-1:0] clamp_width(input logic [31:0] v);
    if (v == '0)     return W'(1);
    else if (v >= F) return LAST;
    else             return v[W-1:0];
  endfunction

  assign align_mode = (bus.cfg_sync_mode == 2'd1) || (bus.cfg_sync_mode == 2'd2);
  assign accept     = bus.sync_in && align_mode &&
                      (state == ARMED || (state == LOCKED && bus.cfg_sync_mode == 2'd2));
  assign realign    = accept && (sub_cnt != '0);
  assign wrap       = (sub_cnt == LAST);
  assign boundary   = wrap || realign;
  // A late reference (second half) means the natural wrap has not counted this second yet.
  assign count_inc  = realign ? (sub_cnt >= HALF) : wrap;
  assign miss_next  = miss_cnt + 1'b1;
  assign lock_lost  = boundary && state == LOCKED && bus.cfg_sync_mode == 2'd2 &&
                      !accept && !seen_sync && (miss_next >= LIMIT);

  // (sub_cnt - phase_act) mod F, computed mod 2^W; the +F term keeps it in 0..F-1.
  assign offset = sub_cnt - phase_act + ((sub_cnt < phase_act) ? F_W : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt   <= '0;
      sec_cnt   <= '0;
      pps       <= 1'b0;
      irq       <= 1'b0;
      sync_err  <= 1'b0;
      tod_pend  <= 1'b0;
      tod_val   <= '0;
      phase_act <= clamp_phase(bus.cfg_phase);
      width_act <= clamp_width(bus.cfg_pulse_width);
    end else begin
      irq <= 1'b0;
      pps <= bus.enable && (offset < width_act);

      if (realign)   sub_cnt <= W'(1);
      else if (wrap) sub_cnt <= '0;
      else           sub_cnt <= sub_cnt + 1'b1;

      if (boundary) begin
        phase_act <= clamp_phase(bus.cfg_phase);
        width_act <= clamp_width(bus.cfg_pulse_width);
        if (tod_pend) begin
          sec_cnt <= tod_val;
          irq     <= 1'b1;
        end else if (count_inc) begin
          sec_cnt <= sec_cnt + 1'b1;
          irq     <= 1'b1;
        end
      end

      // A load on a boundary cycle stays pending for the following boundary.
      if (bus.tod_load) begin
        tod_pend <= 1'b1;
        tod_val  <= bus.tod_value;
      end else if (boundary) begin
        tod_pend <= 1'b0;
      end

      if (bus.err_clear)               sync_err <= 1'b0;
      else if (realign || lock_lost)   sync_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      locked    <= 1'b0;
      miss_cnt  <= '0;
      seen_sync <= 1'b0;
    end else begin
      if (!align_mode) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else if (bus.sync_arm) begin
        state  <= ARMED;
        locked <= 1'b0;
      end else if (state == ARMED && accept) begin
        state  <= LOCKED;
        locked <= 1'b1;
      end else if (lock_lost) begin
        state  <= ARMED;
        locked <= 1'b0;
      end

      // seen_sync: a reference inside the current second; a boundary-making one starts a new second.
      if (lock_lost) begin
        miss_cnt  <= '0;
        seen_sync <= 1'b0;
      end else if (state != LOCKED || bus.cfg_sync_mode != 2'd2) begin
        miss_cnt  <= '0;
        seen_sync <= accept && !boundary;
      end else if (boundary) begin
        seen_sync <= 1'b0;
        miss_cnt  <= (accept || seen_sync) ? '0 : miss_next;
      end else if (accept) begin
        seen_sync <= 1'b1;
        miss_cnt  <= '0;
      end
    end
  end

  assign bus.pps_out       = pps;
  assign bus.sub_sec       = {{(32-W){1'b0}}, sub_cnt};
  assign bus.seconds       = sec_cnt;
  assign bus.irq_second    = irq;
  assign bus.stat_locked   = locked;
  assign bus.stat_sync_err = sync_err;
endmodule
